// File: rtl/demux_1to4_reg.sv
// Purpose : registered 1-to-4 sample demux with a blanking window after each select change.
// Latency : 1 cycle from in_data/in_valid to outN/out_valid.
// Backpres: none; samples arriving during the blanking window are dropped and counted.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_data, in_valid   input sample stream
//   s, s_load           requested destination (00->out1 .. 11->out4) and its capture strobe
//   out1..out4          per-destination data registers (hold when not routed)
//   out_valid[4:1]      one-hot 1-cycle pulse marking the destination updated this cycle
//   active_sel[2:1]     select currently applied to the stream
//   guard               high while samples are being blanked
//   drop_cnt[7:0]       saturating count of blanked samples
module demux_1to4_reg #(
    parameter int WIDTH        = 16,
    parameter int GUARD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic [2:1]       s,
    input  logic             s_load,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [4:1]       out_valid,
    output logic [2:1]       active_sel,
    output logic             guard,
    output logic [7:0]       drop_cnt
);

    localparam logic [7:0] GUARD_LD = 8'(GUARD_CYCLES);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_GUARD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       ctr_q, ctr_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] out_q [4];
    logic [WIDTH-1:0] out_d [4];
    logic [3:0]       vld_q, vld_d;
    logic [7:0]       drop_q, drop_d;
    logic             sel_change;

    // A load that re-requests the current destination is a no-op, not a switch.
    assign sel_change = s_load && (s != sel_q);

    // State register plus all datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            ctr_q   <= 8'd0;
            sel_q   <= 2'b00;
            vld_q   <= 4'b0000;
            drop_q  <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                out_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            sel_q   <= sel_d;
            vld_q   <= vld_d;
            drop_q  <= drop_d;
            for (int i = 0; i < 4; i++) begin
                out_q[i] <= out_d[i];
            end
        end
    end

    // Next-state: select capture and blanking-window counter.
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        sel_d   = sel_q;
        case (state_q)
            ST_RUN: begin
                if (sel_change) begin
                    sel_d = s;
                    if (GUARD_LD != 8'd0) begin
                        state_d = ST_GUARD;
                        ctr_d   = GUARD_LD;
                    end
                end
            end
            ST_GUARD: begin
                if (sel_change) begin
                    // Another switch mid-window restarts the full window.
                    sel_d = s;
                    ctr_d = GUARD_LD;
                end else if (ctr_q <= 8'd1) begin
                    // Last blanked cycle: ctr counts GUARD_CYCLES..1.
                    state_d = ST_RUN;
                    ctr_d   = 8'd0;
                end else begin
                    ctr_d = ctr_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                ctr_d   = 8'd0;
            end
        endcase
    end

    // Output/datapath: routing uses the select in force this cycle, so a sample
    // arriving with a select load still goes to the old destination.
    always_comb begin
        out_d  = out_q;
        vld_d  = 4'b0000;
        drop_d = drop_q;
        if (in_valid) begin
            if (state_q == ST_RUN) begin
                out_d[sel_q] = in_data;
                vld_d[sel_q] = 1'b1;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    assign out1       = out_q[0];
    assign out2       = out_q[1];
    assign out3       = out_q[2];
    assign out4       = out_q[3];
    assign out_valid  = vld_q;
    assign active_sel = sel_q;
    assign guard      = (state_q == ST_GUARD);
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_demux_1to4_reg.sv
// Purpose : self-checking bench for demux_1to4_reg (WIDTH=16, GUARD_CYCLES=2).
// Latency : compares every output 1 cycle after each driven stimulus.
// Backpres: n/a; expected results queued at drive time, popped after the edge.
module tb_demux_1to4_reg;

    localparam int G = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic [2:1]  s;
    logic        s_load;
    logic [15:0] out1, out2, out3, out4;
    logic [4:1]  out_valid;
    logic [2:1]  active_sel;
    logic        guard;
    logic [7:0]  drop_cnt;

    demux_1to4_reg #(.WIDTH(16), .GUARD_CYCLES(G)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .s          (s),
        .s_load     (s_load),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .out4       (out4),
        .out_valid  (out_valid),
        .active_sel (active_sel),
        .guard      (guard),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] outs;
        logic [3:0]  vld;
        logic [1:0]  sel;
        logic        g;
        logic [7:0]  drop;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural reference: guard tracked as cycles remaining, not an FSM.
    logic [15:0] m_out [4];
    logic [3:0]  m_vld;
    logic [1:0]  m_sel;
    int          m_left;
    int          m_drop;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic v, input logic [15:0] d,
                              input logic [1:0] sv, input logic ld);
        if (r) begin
            for (int i = 0; i < 4; i++) m_out[i] = 16'h0;
            m_vld  = 4'b0;
            m_sel  = 2'b00;
            m_left = 0;
            m_drop = 0;
        end else begin
            m_vld = 4'b0;
            if (m_left == 0) begin
                if (v) begin
                    m_out[m_sel] = d;
                    m_vld[m_sel] = 1'b1;
                end
                if (ld && sv != m_sel) begin
                    m_sel  = sv;
                    m_left = G;
                end
            end else begin
                if (v && m_drop < 255) m_drop++;
                if (ld && sv != m_sel) begin
                    m_sel  = sv;
                    m_left = G;
                end else begin
                    m_left--;
                end
            end
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic cycle(input logic r, input logic v, input logic [15:0] d,
                         input logic [1:0] sv, input logic ld);
        exp_t e;
        reset    = r;
        in_valid = v;
        in_data  = d;
        s        = sv;
        s_load   = ld;
        model_step(r, v, d, sv, ld);
        e.outs = {m_out[3], m_out[2], m_out[1], m_out[0]};
        e.vld  = m_vld;
        e.sel  = m_sel;
        e.g    = (m_left != 0);
        e.drop = 8'(m_drop);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            chk("sb_outs",  {out4, out3, out2, out1}, e.outs);
            chk("sb_vld",   64'(out_valid),  64'(e.vld));
            chk("sb_sel",   64'(active_sel), 64'(e.sel));
            chk("sb_guard", 64'(guard),      64'(e.g));
            chk("sb_drop",  64'(drop_cnt),   64'(e.drop));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int gc;
        reset = 1'b1; in_valid = 1'b0; in_data = 16'h0; s = 2'b00; s_load = 1'b0;

        // Reset state
        cycle(1, 1, 16'hFFFF, 2'b11, 1);
        cycle(1, 0, 16'h0, 2'b00, 0);
        chk("rst_outs", {out4, out3, out2, out1}, 64'h0);
        chk("rst_vld",  64'(out_valid), 64'h0);
        chk("rst_sel",  64'(active_sel), 64'h0);
        chk("rst_guard", 64'(guard), 64'h0);
        chk("rst_drop", 64'(drop_cnt), 64'h0);

        // 1: first sample to out1
        cycle(0, 1, 16'h0001, 2'b00, 0);
        chk("t1_out1", 64'(out1), 64'h0001);
        chk("t1_vld",  64'(out_valid), 64'h1);
        chk("t1_others", {out4, out3, out2}, 64'h0);

        // 2: switch with simultaneous sample, two blanked samples, then out2
        cycle(0, 1, 16'h8000, 2'b01, 1);
        chk("t2_out1", 64'(out1), 64'h8000);
        chk("t2_sel",  64'(active_sel), 64'h1);
        chk("t2_g1",   64'(guard), 64'h1);
        cycle(0, 1, 16'h1111, 2'b01, 0);
        chk("t2_g2",   64'(guard), 64'h1);
        chk("t2_vld0", 64'(out_valid), 64'h0);
        cycle(0, 1, 16'h2222, 2'b01, 0);
        chk("t2_g_end", 64'(guard), 64'h0);
        chk("t2_drop", 64'(drop_cnt), 64'h2);
        cycle(0, 1, 16'hC000, 2'b01, 0);
        chk("t2_out2", 64'(out2), 64'hC000);
        chk("t2_vld2", 64'(out_valid), 64'h2);
        chk("t2_out1_hold", 64'(out1), 64'h8000);

        // 3: reloading the same select never blanks
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1, 16'($urandom), 2'b01, 1);
            chk("t3_guard", 64'(guard), 64'h0);
            chk("t3_vld", 64'(out_valid), 64'h2);
        end
        chk("t3_drop", 64'(drop_cnt), 64'h2);

        // 4: second switch inside the window restarts it
        gc = 0;
        cycle(0, 0, 16'h0, 2'b10, 1); gc += int'(guard);
        cycle(0, 0, 16'h0, 2'b11, 1); gc += int'(guard);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 16'h0, 2'b11, 0); gc += int'(guard);
        end
        chk("t4_guard_cycles", 64'(gc), 64'd3);
        chk("t4_sel", 64'(active_sel), 64'h3);
        cycle(0, 1, 16'hF000, 2'b11, 0);
        chk("t4_out4", 64'(out4), 64'hF000);
        chk("t4_vld",  64'(out_valid), 64'h8);
        chk("t4_out3", 64'(out3), 64'h0);

        // 5: sustained re-switching saturates the drop counter
        for (int i = 0; i < 300; i++) begin
            cycle(0, 1, 16'(i), (i % 2 == 0) ? 2'b10 : 2'b01, 1);
        end
        chk("t5_drop_sat", 64'(drop_cnt), 64'hFF);
        chk("t5_in_guard", 64'(guard), 64'h1);

        // 6: reset mid-window wins over load and sample
        cycle(1, 1, 16'hABCD, 2'b11, 1);
        chk("t6_guard", 64'(guard), 64'h0);
        chk("t6_sel",   64'(active_sel), 64'h0);
        chk("t6_outs",  {out4, out3, out2, out1}, 64'h0);
        chk("t6_drop",  64'(drop_cnt), 64'h0);
        chk("t6_vld",   64'(out_valid), 64'h0);

        cycle(0, 1, 16'h5A5A, 2'b00, 0);
        chk("t6_after", 64'(out1), 64'h5A5A);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
